demux_router: RTL and testbench
===============================

Name: demux_router

Overview:
- Registered, flow-controlled demultiplexer that routes one data word per beat from a single producer to one of NUM_CH consumer channels, e.g. the k-means cluster units, selected by a 1-based index.
- Index 0 means "no destination". A broadcast mode delivers the same word to every channel.
- Sits between the sample/centroid distribution stage and the per-cluster accumulators.
- Adds what the combinational 8-way demux lacks: parametrised channel count, valid/ready backpressure, one-cycle registered output, per-channel independent acceptance in broadcast, and drop accounting.

Parameters:
- DATA_W, 91, width of the routed data word.
- NUM_CH, 8, number of output channels (2..32).
- IDX_W, $clog2(NUM_CH+1), width of the index field (must hold 0..NUM_CH).
- CNT_W, 16, width of the drop counter.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  router accepts the word this cycle.
- in_data  input  DATA_W  word to route.
- in_index  input  IDX_W  destination channel, 1..NUM_CH; 0 = none.
- in_bcast  input  1  deliver to all channels; in_index is ignored.
- out_valid  output  NUM_CH  per-channel valid; bit k-1 is channel k.
- out_ready  input  NUM_CH  per-channel ready.
- out_data  output  DATA_W  held word, shared by all channels.
- drop_count  output  CNT_W  number of accepted words with no valid destination.
- busy  output  1  holding register occupied.

Behaviour:
- Reset (rst=1 at a clock edge): pending mask <= 0, so out_valid = 0. busy = 0. drop_count = 0. out_data = 0. in_ready is 1 in the cycle after reset.
- State is a single holding register: data plus NUM_CH-bit pending mask. EMPTY when mask==0, FULL otherwise. busy = (mask != 0).
- out_valid = pending mask. out_data = held data.
- Per-channel acceptance: channel k is accepted on a cycle when out_valid[k-1] && out_ready[k-1]. Its mask bit clears at that edge.
- Retire: the register retires when every set mask bit is accepted this cycle, i.e. (mask & ~out_ready) == 0.
- in_ready = EMPTY || retire. This is a combinational path from out_ready and is deliberate: it gives full throughput of one word per cycle.
- Input fire = in_valid && in_ready. On fire, the next mask is:
  - in_bcast=1: all ones.
  - in_index in 1..NUM_CH: one-hot bit in_index-1.
  - in_index = 0 or > NUM_CH: zero.
- Data register loads in_data on fire only. It is held otherwise.
- Zero-mask fire:
  - word is dropped and never presented;
  - drop_count increments, saturating at all ones;
  - register stays/becomes EMPTY;
  - in_ready stays 1.
- Latency: a word accepted at edge N is presented (out_valid set) from cycle N+1. Minimum input-to-output latency is 1 cycle.
- Fire and retire in the same cycle: the new mask replaces the old. There is no bubble.
- Broadcast:
  - channels may accept in different cycles; an accepted channel's valid drops while the others stay asserted;
  - a channel never sees the same word twice;
  - the next word is not taken until all channels have accepted.
- out_ready on channels whose mask bit is 0 is ignored.
- Stability: while out_valid[k-1]=1 and not accepted, out_data and that valid bit must not change.
- Reset mid-operation: held word and pending mask are discarded with no further valid. drop_count clears.
- in_index/in_bcast are sampled only on fire.

Decomposition:
- Shared package demux_pkg holds:
  - function idx_to_mask(index, bcast), returning a NUM_CH-bit mask;
  - localparam DEFAULT_DATA_W = 91;
  - localparam DEFAULT_NUM_CH = 8.
- One natural sub-module, sat_counter (width CNT_W, synchronous reset, increment enable, saturate), for drop_count. It is reusable elsewhere in the project.
- Core holding register and mask logic stay in demux_router.

Test Plan:
1. Reset, then in_valid=1, in_index=3, in_data=0x5A, all out_ready=1 -> next cycle out_valid=8'b0000_0100, out_data=0x5A. Following cycle out_valid=0. in_ready stays 1 throughout.
2. Back-to-back indices 1,2,...,8 on consecutive cycles, all ready -> out_valid walks one-hot 0x01..0x80 on consecutive cycles with no bubbles. Eight words delivered in 9 cycles.
3. Index 5 with out_ready[4]=0 for 3 cycles -> out_valid=0x10 held and out_data stable for 3 cycles. in_ready=0 during the stall. The word retires in the cycle out_ready[4] rises, and a new word is accepted in that same cycle.
4. Broadcast of 0x123 with out_ready=0x0F first cycle, 0xF0 second -> out_valid=0xFF, then 0xF0, then 0x00. in_ready is low on the first cycle and high on the second.
5. Index 0, then index 9 (NUM_CH=8) -> no out_valid asserted, drop_count reads 2. With CNT_W=2 and 5 drops, drop_count saturates at 3.
6. Word pending on channel 2 (stalled), assert rst for one cycle -> out_valid=0, busy=0, drop_count=0 next cycle. The old word never reappears.

Source files
------------

// File: rtl/demux_router_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the demux_router block:
//   - default data width and channel count
//   - holding-register occupancy state type
//   - idx_to_mask(): converts a 1-based destination index (or broadcast flag)
//     into a channel mask. The mask is returned at the maximum supported
//     width (32 channels); callers keep the low NUM_CH bits.
// ----------------------------------------------------------------------------
package demux_pkg;

    localparam int DEFAULT_DATA_W = 91;
    localparam int DEFAULT_NUM_CH = 8;

    // Upper bound on channel count and the index width able to hold 0..32.
    localparam int MAX_CH    = 32;
    localparam int IDX_EXT_W = 6;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_t;

    // Broadcast -> low num_ch bits set.
    // Index 1..num_ch -> one-hot bit index-1.
    // Index 0 or beyond num_ch -> zero mask (word has no destination).
    function automatic logic [MAX_CH-1:0] idx_to_mask(
        input logic [IDX_EXT_W-1:0] index,
        input logic                 bcast,
        input int                   num_ch
    );
        logic [MAX_CH-1:0] mask;
        mask = '0;
        if (bcast) begin
            if (num_ch >= MAX_CH) begin
                mask = '1;
            end else begin
                mask = (MAX_CH'(1) << num_ch) - MAX_CH'(1);
            end
        end else if ((index != '0) && (int'(index) <= num_ch)) begin
            mask = MAX_CH'(1) << (index - IDX_EXT_W'(1));
        end
        return mask;
    endfunction

endpackage

// File: rtl/demux_router_if.sv
// ----------------------------------------------------------------------------
// demux_router_if
// Handshake bundle between one producer, the router and NUM_CH consumers.
//   in_valid/in_ready/in_data/in_index/in_bcast : producer side
//   out_valid/out_ready/out_data                : consumer side (per-channel
//                                                 valid/ready, shared data)
// Modports:
//   master : the environment (drives producer request and consumer ready)
//   slave  : the router
// ----------------------------------------------------------------------------
interface demux_router_if #(
    parameter int DATA_W = demux_pkg::DEFAULT_DATA_W,
    parameter int NUM_CH = demux_pkg::DEFAULT_NUM_CH,
    parameter int IDX_W  = $clog2(NUM_CH + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  in_index;
    logic              in_bcast;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_index, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_index, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_router_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all ones instead of wrapping.
//   clk     : clock
//   rst     : synchronous active-high reset, clears the count
//   i_inc   : increment enable for this cycle
//   o_count : current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_reg <= '0;
        end else if (i_inc && (r_count_reg != '1)) begin
            r_count_reg <= r_count_reg + W'(1);
        end
    end

    assign o_count = r_count_reg;
endmodule

// File: rtl/demux_router.sv
// ----------------------------------------------------------------------------
// demux_router
// Registered, flow-controlled demultiplexer: one word per beat from a single
// producer to one of NUM_CH channels (1-based index), or to all channels in
// broadcast mode. Index 0 / out-of-range words are dropped and counted.
//   clk        : clock
//   rst        : synchronous active-high reset
//   bus        : demux_router_if.slave (producer + per-channel consumer side)
//   drop_count : accepted words that had no destination (saturating)
//   busy       : holding register occupied (pending mask non-zero)
// ----------------------------------------------------------------------------
module demux_router
    import demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int IDX_W  = $clog2(NUM_CH + 1),
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    demux_router_if.slave    bus,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);
    // Holding register: shared data word plus one pending bit per channel.
    logic [NUM_CH-1:0] r_mask_reg;
    logic [DATA_W-1:0] r_data_reg;

    logic [NUM_CH-1:0]    w_mask_next;
    logic [NUM_CH-1:0]    w_new_mask;
    logic [MAX_CH-1:0]    w_mask_full;
    logic [IDX_EXT_W-1:0] w_idx_ext;
    hold_state_t          w_state;
    logic                 w_retire;
    logic                 w_in_ready;
    logic                 w_fire;
    logic                 w_drop;

    assign w_state = (r_mask_reg != '0) ? ST_FULL : ST_EMPTY;

    // Every still-pending channel is taking the word this cycle. Ready on
    // channels that are not pending is masked out here.
    assign w_retire = ((r_mask_reg & ~bus.out_ready) == '0);

    // Combinational ready from out_ready keeps one word per cycle through the
    // register when consumers are ready.
    assign w_in_ready = (w_state == ST_EMPTY) || w_retire;
    assign w_fire     = bus.in_valid && w_in_ready;

    assign w_idx_ext   = IDX_EXT_W'(bus.in_index);
    assign w_mask_full = idx_to_mask(w_idx_ext, bus.in_bcast, NUM_CH);
    assign w_new_mask  = w_mask_full[NUM_CH-1:0];

    // A fired word with no destination never enters the register.
    assign w_drop = w_fire && (w_new_mask == '0);

    // On fire the new mask replaces whatever is left (the old word is retiring
    // this same cycle); otherwise accepted channels clear individually.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
        assign w_mask_next[gi] = w_fire ? w_new_mask[gi]
                                        : (r_mask_reg[gi] & ~bus.out_ready[gi]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask_reg <= '0;
            r_data_reg <= '0;
        end else begin
            r_mask_reg <= w_mask_next;
            if (w_fire) begin
                r_data_reg <= bus.in_data;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_drop_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_drop),
        .o_count (drop_count)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_mask_reg;
    assign bus.out_data  = r_data_reg;
    assign busy          = (w_state == ST_FULL);
endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;
    localparam int DATA_W = 91;
    localparam int NUM_CH = 8;
    localparam int IDX_W  = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [15:0] drop_count;
    logic        busy;
    logic [1:0]  drop_count2;
    logic        busy2;

    demux_router_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .IDX_W(IDX_W)) bus ();
    demux_router_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .IDX_W(IDX_W)) bus2 ();

    demux_router #(
        .DATA_W (DATA_W), .NUM_CH (NUM_CH), .IDX_W (IDX_W), .CNT_W (16)
    ) dut (
        .clk (clk), .rst (rst), .bus (bus), .drop_count (drop_count), .busy (busy)
    );

    demux_router #(
        .DATA_W (DATA_W), .NUM_CH (NUM_CH), .IDX_W (IDX_W), .CNT_W (2)
    ) dut2 (
        .clk (clk), .rst (rst), .bus (bus2), .drop_count (drop_count2), .busy (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] idx, input logic bc,
                         input logic [DATA_W-1:0] d);
        bus.in_valid = v;
        bus.in_index = idx;
        bus.in_bcast = bc;
        bus.in_data  = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(1'b0, 4'd0, 1'b0, '0);
        bus.out_ready  = 8'h00;
        bus2.in_valid  = 1'b0;
        bus2.in_index  = 4'd0;
        bus2.in_bcast  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 8'hFF;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---- reset state
        chk("rst_out_valid", 128'(bus.out_valid), 128'h0);
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_drop", 128'(drop_count), 128'h0);
        chk("rst_out_data", 128'(bus.out_data), 128'h0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'h1);

        // ---- 1: single word to channel 3
        bus.out_ready = 8'hFF;
        drive(1'b1, 4'd3, 1'b0, 91'h5A);
        #1;
        chk("t1_in_ready_a", 128'(bus.in_ready), 128'h1);
        tick();
        drive(1'b0, 4'd0, 1'b0, '0);
        chk("t1_out_valid", 128'(bus.out_valid), 128'h04);
        chk("t1_out_data", 128'(bus.out_data), 128'h5A);
        chk("t1_busy", 128'(busy), 128'h1);
        chk("t1_in_ready_b", 128'(bus.in_ready), 128'h1);
        tick();
        chk("t1_out_valid_clr", 128'(bus.out_valid), 128'h0);
        chk("t1_in_ready_c", 128'(bus.in_ready), 128'h1);

        // ---- 2: back-to-back indices 1..8, no bubbles
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 4'(k), 1'b0, DATA_W'(32'h100 + k));
            #1;
            chk($sformatf("t2_in_ready_%0d", k), 128'(bus.in_ready), 128'h1);
            tick();
            chk($sformatf("t2_out_valid_%0d", k), 128'(bus.out_valid), 128'(8'h01 << (k - 1)));
            chk($sformatf("t2_out_data_%0d", k), 128'(bus.out_data), 128'(32'h100 + k));
        end
        drive(1'b0, 4'd0, 1'b0, '0);
        tick();
        chk("t2_out_valid_end", 128'(bus.out_valid), 128'h0);

        // ---- 3: channel 5 stalled for 3 cycles, then retire + accept same cycle
        bus.out_ready = 8'hEF;
        drive(1'b1, 4'd5, 1'b0, 91'hAB);
        tick();
        drive(1'b1, 4'd2, 1'b0, 91'hCD);
        for (int s = 1; s <= 3; s++) begin
            #1;
            chk($sformatf("t3_stall_valid_%0d", s), 128'(bus.out_valid), 128'h10);
            chk($sformatf("t3_stall_data_%0d", s), 128'(bus.out_data), 128'hAB);
            chk($sformatf("t3_stall_in_ready_%0d", s), 128'(bus.in_ready), 128'h0);
            if (s < 3) tick();
        end
        bus.out_ready = 8'hFF;
        #1;
        chk("t3_retire_in_ready", 128'(bus.in_ready), 128'h1);
        tick();
        drive(1'b0, 4'd0, 1'b0, '0);
        chk("t3_next_valid", 128'(bus.out_valid), 128'h02);
        chk("t3_next_data", 128'(bus.out_data), 128'hCD);
        tick();
        chk("t3_end_valid", 128'(bus.out_valid), 128'h0);

        // ---- 4: broadcast with split acceptance; index ignored
        bus.out_ready = 8'h0F;
        drive(1'b1, 4'd3, 1'b1, 91'h123);
        #1;
        chk("t4_in_ready_empty", 128'(bus.in_ready), 128'h1);
        tick();
        drive(1'b0, 4'd0, 1'b0, '0);
        chk("t4_valid_all", 128'(bus.out_valid), 128'hFF);
        chk("t4_data", 128'(bus.out_data), 128'h123);
        chk("t4_in_ready_low", 128'(bus.in_ready), 128'h0);
        tick();
        chk("t4_valid_upper", 128'(bus.out_valid), 128'hF0);
        chk("t4_data_held", 128'(bus.out_data), 128'h123);
        bus.out_ready = 8'hF0;
        #1;
        chk("t4_in_ready_high", 128'(bus.in_ready), 128'h1);
        tick();
        chk("t4_valid_none", 128'(bus.out_valid), 128'h0);

        // ---- 5: dropped words (index 0 and index 9)
        bus.out_ready = 8'hFF;
        drive(1'b1, 4'd0, 1'b0, 91'h99);
        tick();
        chk("t5_idx0_valid", 128'(bus.out_valid), 128'h0);
        chk("t5_idx0_busy", 128'(busy), 128'h0);
        chk("t5_idx0_in_ready", 128'(bus.in_ready), 128'h1);
        drive(1'b1, 4'd9, 1'b0, 91'h98);
        tick();
        drive(1'b0, 4'd0, 1'b0, '0);
        chk("t5_idx9_valid", 128'(bus.out_valid), 128'h0);
        chk("t5_drop_count", 128'(drop_count), 128'h2);
        tick();
        chk("t5_drop_count_hold", 128'(drop_count), 128'h2);

        // saturation on the 2-bit counter instance
        bus2.in_valid = 1'b1;
        bus2.in_index = 4'd0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk($sformatf("t5_sat_drop_%0d", n), 128'(drop_count2), 128'((n > 3) ? 3 : n));
        end
        bus2.in_valid = 1'b0;
        chk("t5_sat_valid", 128'(bus2.out_valid), 128'h0);

        // ---- 6: reset with a stalled word on channel 2
        bus.out_ready = 8'hFD;
        drive(1'b1, 4'd2, 1'b0, 91'hEE);
        tick();
        drive(1'b0, 4'd0, 1'b0, '0);
        chk("t6_pending", 128'(bus.out_valid), 128'h02);
        tick();
        chk("t6_still_pending", 128'(bus.out_valid), 128'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", 128'(bus.out_valid), 128'h0);
        chk("t6_rst_busy", 128'(busy), 128'h0);
        chk("t6_rst_drop", 128'(drop_count), 128'h0);
        chk("t6_rst_data", 128'(bus.out_data), 128'h0);
        chk("t6_rst_sat_drop", 128'(drop_count2), 128'h0);
        bus.out_ready = 8'hFF;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("t6_no_reappear_%0d", c), 128'(bus.out_valid), 128'h0);
        end
        chk("t6_in_ready", 128'(bus.in_ready), 128'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
